// File: rtl/segre_pkg.sv
// Shared types and constants for the segre core.
// Holds the ALU opcode set (including the divide/multiply ops run by the
// EX-stage sequencer) and the sequencer FSM state type.
package segre_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned SEQ_ITERS = WORD_SIZE;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_LUI,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU
    } alu_opcode_e;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_CALC,
        SEQ_DONE
    } ex_seq_state_e;

    function automatic logic is_div_op(alu_opcode_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_mul_op(alu_opcode_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

endpackage

// File: rtl/segre_ex_seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, try to subtract the divisor, keep the difference if it did not
// borrow and shift the matching quotient bit in.
module segre_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    // Trial subtraction; the top bit of trial is the borrow.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {2'b00, div_i};
        if (trial[XLEN+1]) begin
            rem_o = shifted[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = trial[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/segre_ex_seq.sv
// Multi-cycle EX-stage sequencer for divide/remainder (and optionally multiply).
// Stalls the pipeline while an op iterates and delivers one registered result
// with a single-cycle res_valid_o pulse.
// Build option: define SEGRE_EX_SEQ_MUL_EN to sequence MUL/MULH/MULHSU/MULHU;
// otherwise those opcodes only raise illegal_o.
module segre_ex_seq
    import segre_pkg::*;
#(
    parameter int unsigned XLEN = WORD_SIZE
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            valid_i,
    input  alu_opcode_e     alu_opcode_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            res_valid_o,
    output logic [XLEN-1:0] res_o,
    output logic            illegal_o
);

    localparam int unsigned     CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    ex_seq_state_e    state_q, state_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    alu_opcode_e      op_q;
    logic             neg_q;
    logic [XLEN:0]    rem_q;
    logic [XLEN-1:0]  quo_q, div_q, res_q;

    logic op_is_div, op_is_mul, op_is_rem, seq_op;
    logic a_signed, b_signed, a_neg, b_neg, res_neg;
    logic div_by_zero, div_ovf, fast_path, accept, calc_last, load_res;
    logic [XLEN-1:0] a_mag, b_mag, fast_res, load_quo, load_div;
    logic [XLEN:0]   step_rem, iter_rem;
    logic [XLEN-1:0] step_quo, iter_quo, div_raw, calc_res, res_d;

`ifdef SEGRE_EX_SEQ_MUL_EN
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
`endif

    // Decode the incoming op: magnitudes, result sign and fast-path cases.
    always_comb begin
        op_is_div   = is_div_op(alu_opcode_i);
        op_is_mul   = is_mul_op(alu_opcode_i);
        op_is_rem   = alu_opcode_i inside {ALU_REM, ALU_REMU};
        a_signed    = alu_opcode_i inside {ALU_DIV, ALU_REM, ALU_MULH, ALU_MULHSU};
        b_signed    = alu_opcode_i inside {ALU_DIV, ALU_REM, ALU_MULH};
        a_neg       = a_signed & src_a_i[XLEN-1];
        b_neg       = b_signed & src_b_i[XLEN-1];
        a_mag       = a_neg ? -src_a_i : src_a_i;
        b_mag       = b_neg ? -src_b_i : src_b_i;
        // Remainder takes the dividend's sign, quotient/product the xor.
        res_neg     = op_is_rem ? a_neg : (a_neg ^ b_neg);
        div_by_zero = (src_b_i == '0);
        div_ovf     = a_signed & (src_a_i == XLEN_MIN) & (src_b_i == '1);
        fast_path   = op_is_div & (div_by_zero | div_ovf);
        if (div_by_zero) begin
            fast_res = op_is_rem ? src_a_i : '1;
        end else begin
            fast_res = op_is_rem ? '0 : XLEN_MIN;
        end
`ifdef SEGRE_EX_SEQ_MUL_EN
        seq_op    = op_is_div | op_is_mul;
        illegal_o = 1'b0;
        // Multiply keeps the multiplier in quo_q and the multiplicand in div_q.
        load_quo  = op_is_mul ? b_mag : a_mag;
        load_div  = op_is_mul ? a_mag : b_mag;
`else
        seq_op    = op_is_div;
        illegal_o = rsn_i & valid_i & op_is_mul & ~flush_i & (state_q == SEQ_IDLE);
        load_quo  = a_mag;
        load_div  = b_mag;
`endif
        accept    = rsn_i & valid_i & seq_op & ~flush_i & (state_q == SEQ_IDLE);
        calc_last = (state_q == SEQ_CALC) & (cnt_q == CNT_LAST);
        load_res  = (accept & fast_path) | (calc_last & ~flush_i);
    end

    segre_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Per-iteration datapath and the sign-corrected final result.
    always_comb begin
        iter_rem = step_rem;
        iter_quo = step_quo;
        div_raw  = (op_q inside {ALU_REM, ALU_REMU}) ? step_rem[XLEN-1:0] : step_quo;
        calc_res = neg_q ? -div_raw : div_raw;
`ifdef SEGRE_EX_SEQ_MUL_EN
        // Shift-add: {rem_q[XLEN-1:0], quo_q} is the 2*XLEN accumulator.
        mul_sum  = {1'b0, rem_q[XLEN-1:0]} + (quo_q[0] ? {1'b0, div_q} : '0);
        mul_lo   = {mul_sum[0], quo_q[XLEN-1:1]};
        prod     = {mul_sum[XLEN:1], mul_lo};
        prod_fix = neg_q ? -prod : prod;
        if (is_mul_op(op_q)) begin
            iter_rem = {1'b0, mul_sum[XLEN:1]};
            iter_quo = mul_lo;
            calc_res = (op_q == ALU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
`endif
        res_d = accept ? fast_res : calc_res;
    end

    // Next-state logic; flush always returns to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEQ_IDLE: if (accept) state_d = fast_path ? SEQ_DONE : SEQ_CALC;
            SEQ_CALC: if (cnt_q == CNT_LAST) state_d = SEQ_DONE;
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
        if (flush_i) state_d = SEQ_IDLE;
    end

    // State register and registered busy flag.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= SEQ_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != SEQ_IDLE);
        end
    end

    // Operand capture on accept, one step per cycle while calculating.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            op_q  <= ALU_ADD;
            neg_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (accept) begin
            op_q  <= alu_opcode_i;
            neg_q <= res_neg;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= load_quo;
            div_q <= load_div;
        end else if (state_q == SEQ_CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= iter_rem;
            quo_q <= iter_quo;
        end
    end

    // Result register; written on entry to DONE, held otherwise.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            res_q <= '0;
        end else if (load_res) begin
            res_q <= res_d;
        end
    end

    assign stall_o     = accept | (state_q == SEQ_CALC);
    assign busy_o      = busy_q;
    assign res_valid_o = (state_q == SEQ_DONE) & ~flush_i;
    assign res_o       = res_q;

endmodule

// File: tb/tb_segre_ex_seq.sv
// Self-checking bench for segre_ex_seq: a timeline model (accept cycle, done
// cycle, expected result from plain integer arithmetic) is compared against
// the DUT on every falling edge, plus literal result checks.
module tb_segre_ex_seq;
    import segre_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MIN  = 32'h8000_0000;
`ifdef SEGRE_EX_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        valid_i;
    alu_opcode_e alu_opcode_i;
    logic [31:0] src_a_i, src_b_i;
    logic        flush_i;
    logic        stall_o, busy_o, res_valid_o, illegal_o;
    logic [31:0] res_o;

    segre_ex_seq #(
        .XLEN (XLEN)
    ) dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .valid_i      (valid_i),
        .alu_opcode_i (alu_opcode_i),
        .src_a_i      (src_a_i),
        .src_b_i      (src_b_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .res_valid_o  (res_valid_o),
        .res_o        (res_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Timeline model of the op in flight.
    int          m_acc = -1, m_stall_last = -1, m_busy_last = -1, m_done = -1, m_ill = -1;
    logic [31:0] m_res_old = '0, m_res_new = '0;

    alu_opcode_e op_tab [10] = '{ALU_ADD, ALU_SUB, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
                                 ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, got, exp);
        end
    endfunction

    function automatic logic [31:0] ref_result(alu_opcode_e op, logic [31:0] a, logic [31:0] b);
        logic [63:0]        p;
        logic signed [63:0] ps;
        case (op)
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return $signed(a) / $signed(b);
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            ALU_MUL: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            ALU_MULHU: begin
                p = {32'b0, a} * {32'b0, b};
                return p[63:32];
            end
            ALU_MULH: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return ps[63:32];
            end
            ALU_MULHSU: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return ps[63:32];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            6:       return 32'(0 - $urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // Per-cycle comparison of every output against the timeline model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("stall_o", 32'(stall_o),
                  32'((m_acc >= 0) && (cyc >= m_acc) && (cyc <= m_stall_last)));
            check("busy_o", 32'(busy_o),
                  32'((m_acc >= 0) && (cyc > m_acc) && (cyc <= m_busy_last)));
            check("res_valid_o", 32'(res_valid_o), 32'((m_done >= 0) && (cyc == m_done)));
            check("illegal_o", 32'(illegal_o), 32'(cyc == m_ill));
            check("res_o", res_o, ((m_done >= 0) && (cyc >= m_done)) ? m_res_new : m_res_old);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first cycle a new op may start.
    // fl: -1 no flush, 0 flush in the presenting cycle, k>0 flush k cycles later.
    task automatic do_op(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                         input int fl, input bit lit_en, input logic [31:0] lit);
        bit divop, mulop, seq, fast;
        int a0, len;
        divop = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        mulop = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
        seq   = divop || (mulop && MUL_EN);
        fast  = divop && ((b == 0) ||
                ((op == ALU_DIV || op == ALU_REM) && a == MIN && b == 32'hFFFF_FFFF));
        len   = fast ? 1 : XLEN + 1;
        a0    = cyc;
        valid_i = 1'b1; alu_opcode_i = op; src_a_i = a; src_b_i = b; flush_i = (fl == 0);
        if (!seq || fl == 0) begin
            if (mulop && !MUL_EN && fl != 0) m_ill = a0;
            @(posedge clk_i); #1;
            valid_i = 1'b0; flush_i = 1'b0;
            return;
        end
        m_res_new = ref_result(op, a, b);
        if (fl > 0 && fl < len) begin
            m_stall_last = a0 + fl; m_busy_last = a0 + fl; m_done = -1; m_acc = a0;
            repeat (fl) begin @(posedge clk_i); #1; end
            flush_i = 1'b1;
            @(posedge clk_i); #1;
            flush_i = 1'b0; valid_i = 1'b0; m_acc = -1;
            check("flush_keeps_res", res_o, m_res_old);
        end else begin
            m_stall_last = a0 + len - 1; m_busy_last = a0 + len; m_done = a0 + len; m_acc = a0;
            repeat (len) begin @(posedge clk_i); #1; end
            valid_i = 1'b0;
            if (lit_en) begin
                @(negedge clk_i);
                check("literal_res", res_o, lit);
            end
            @(posedge clk_i); #1;
            m_res_old = m_res_new; m_acc = -1; m_done = -1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rsn_i = 1'b0; valid_i = 1'b0; alu_opcode_i = ALU_ADD;
        src_a_i = '0; src_b_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_stall", 32'(stall_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        check("reset_valid", 32'(res_valid_o), 32'h0);
        check("reset_illegal", 32'(illegal_o), 32'h0);
        check("reset_res", res_o, 32'h0);
        rsn_i = 1'b1; chk_en = 1'b1;

        do_op(ALU_DIVU, 32'd100, 32'd7, -1, 1'b1, 32'd14);
        do_op(ALU_REMU, 32'd100, 32'd7, -1, 1'b1, 32'd2);
        do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b1, 32'hFFFF_FFFD);
        do_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, -1, 1'b1, 32'hFFFF_FFFF);
        do_op(ALU_DIV, 32'd7, 32'hFFFF_FFFE, -1, 1'b1, 32'hFFFF_FFFD);
        do_op(ALU_DIV, 32'd5, 32'd0, -1, 1'b1, 32'hFFFF_FFFF);
        do_op(ALU_REMU, 32'd5, 32'd0, -1, 1'b1, 32'd5);
        do_op(ALU_DIV, MIN, 32'hFFFF_FFFF, -1, 1'b1, MIN);
        do_op(ALU_REM, MIN, 32'hFFFF_FFFF, -1, 1'b1, 32'h0);
        do_op(ALU_DIVU, 32'd1000, 32'd3, 10, 1'b0, 32'h0);
        do_op(ALU_DIVU, 32'd9, 32'd3, -1, 1'b1, 32'd3);
        do_op(ALU_DIVU, 32'd50, 32'd5, 0, 1'b0, 32'h0);
        do_op(ALU_ADD, 32'd1, 32'd2, -1, 1'b0, 32'h0);
`ifdef SEGRE_EX_SEQ_MUL_EN
        do_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'hFFFF_FFFE);
        do_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'h0000_0001);
`else
        do_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 32'h0);
        do_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 32'h0);
`endif

        // Asynchronous reset in the middle of a divide.
        a0 = cyc;
        valid_i = 1'b1; alu_opcode_i = ALU_DIV; src_a_i = 32'd1000; src_b_i = 32'd7;
        m_res_new = ref_result(ALU_DIV, 32'd1000, 32'd7);
        m_stall_last = a0 + XLEN; m_busy_last = a0 + XLEN + 1; m_done = a0 + XLEN + 1;
        m_acc = a0;
        repeat (15) begin @(posedge clk_i); #1; end
        chk_en = 1'b0; rsn_i = 1'b0;
        #1;
        check("midrst_stall", 32'(stall_o), 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);
        check("midrst_valid", 32'(res_valid_o), 32'h0);
        check("midrst_illegal", 32'(illegal_o), 32'h0);
        check("midrst_res", res_o, 32'h0);
        valid_i = 1'b0; m_acc = -1; m_done = -1; m_res_old = '0;
        @(posedge clk_i); #1;
        rsn_i = 1'b1; chk_en = 1'b1;
        do_op(ALU_DIVU, 32'd8, 32'd2, -1, 1'b1, 32'd4);

        // Randomized ops, some flushed, with occasional idle gaps.
        for (int i = 0; i < 60; i++) begin
            alu_opcode_e op;
            int          fl;
            op = op_tab[$urandom_range(0, 9)];
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 33)) : -1;
            do_op(op, rand_opnd(), rand_opnd(), fl, 1'b0, 32'h0);
            repeat ($urandom_range(0, 1)) begin @(posedge clk_i); #1; end
        end

        repeat (2) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
